// File: rtl/anim_pkg.sv
// anim_pkg: shared state encoding and default screen geometry for the box animator.
package anim_pkg;
    typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, MOVE} state_e;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W_DEF = 3;
endpackage

// File: rtl/box_scan.sv
// box_scan: raster counters over the sprite, shared by the draw and erase passes.
module box_scan #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1,
    parameter int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] cx_o,
    output logic [RW-1:0] cy_o,
    output logic [CW-1:0] nx_o,
    output logic [RW-1:0] ny_o,
    output logic          last_o
);
    logic [CW-1:0] cx_q;
    logic [RW-1:0] cy_q;
    logic          end_row;

    assign end_row = (cx_q == CW'(BOX_W - 1));
    assign last_o  = end_row && (cy_q == RW'(BOX_H - 1));
    assign nx_o    = end_row ? '0 : cx_q + 1'b1;
    assign ny_o    = end_row ? cy_q + 1'b1 : cy_q;
    assign cx_o    = cx_q;
    assign cy_o    = cy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (clr_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else if (adv_i) begin
            cx_q <= nx_o;
            cy_q <= ny_o;
        end
    end
endmodule

// File: rtl/box_animator.sv
// box_animator: draws, holds, erases and bounces a sprite through a ready/valid pixel port.
module box_animator
    import anim_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int COLOUR_W = COLOUR_W_DEF,
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int FRAME_TICKS = 12_500_000,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                iLoad,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic [1:0]          iStep,
    input  logic                iEnable,
    input  logic                iReady,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oFrame
);
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [X_W-1:0] LIM_X = X_W'(SCREEN_W - BOX_W);
    localparam logic [Y_W-1:0] LIM_Y = Y_W'(SCREEN_H - BOX_H);

    state_e              state_q, state_d;
    logic [X_W-1:0]      px_q, px_d, ox_q, ox_d;
    logic [Y_W-1:0]      py_q, py_d, oy_q, oy_d;
    logic                dx_q, dx_d, dy_q, dy_d;
    logic [COLOUR_W-1:0] col_q, col_d, oc_q, oc_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic                plot_q, plot_d, busy_q, busy_d, frame_q, frame_d;
    logic                sc_clr, sc_adv, sc_last;
    logic [CW-1:0]       cx, nx;
    logic [RW-1:0]       cy, ny;
    logic [X_W:0]        ex, stx, sx, dfx;
    logic [Y_W:0]        ey, sty, sy, dfy;

    box_scan #(.BOX_W(BOX_W), .BOX_H(BOX_H), .CW(CW), .RW(RW)) u_scan (
        .clk(clock), .rst_n(resetn), .clr_i(sc_clr), .adv_i(sc_adv),
        .cx_o(cx), .cy_o(cy), .nx_o(nx), .ny_o(ny), .last_o(sc_last)
    );

    // Bounce arithmetic is one bit wider than the coordinate so nothing wraps.
    assign ex  = {1'b0, px_q};
    assign stx = (X_W+1)'(iStep);
    assign sx  = ex + stx;
    assign dfx = ex - stx;
    assign ey  = {1'b0, py_q};
    assign sty = (Y_W+1)'(iStep);
    assign sy  = ey + sty;
    assign dfy = ey - sty;

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        col_d   = col_q;
        tick_d  = '0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        oc_d    = oc_q;
        plot_d  = plot_q;
        sc_clr  = 1'b0;
        sc_adv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iLoad) begin
                    px_d = (iX > LIM_X) ? LIM_X : iX;
                    py_d = (iY > LIM_Y) ? LIM_Y : iY;
                    dx_d = 1'b0;
                    dy_d = 1'b0;
                end
                if (iEnable) begin
                    state_d = DRAW;
                    col_d   = iColour;
                end
            end
            DRAW, ERASE: begin
                oc_d = (state_q == DRAW) ? col_q : BG_COLOUR;
                if (!plot_q) begin
                    plot_d = 1'b1;
                    ox_d   = px_q + X_W'(cx);
                    oy_d   = py_q + Y_W'(cy);
                end else if (iReady && sc_last) begin
                    plot_d  = 1'b0;
                    sc_clr  = 1'b1;
                    state_d = (state_q == DRAW) ? WAIT : MOVE;
                end else if (iReady) begin
                    sc_adv = 1'b1;
                    ox_d   = px_q + X_W'(nx);
                    oy_d   = py_q + Y_W'(ny);
                end
            end
            WAIT: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TW'(FRAME_TICKS - 1)) begin
                    tick_d  = '0;
                    state_d = iEnable ? ERASE : IDLE;
                end
            end
            MOVE: begin
                px_d    = dx_q ? ((ex >= stx) ? dfx[X_W-1:0] : '0) : ((sx <= {1'b0, LIM_X}) ? sx[X_W-1:0] : LIM_X);
                dx_d    = dx_q ? (ex >= stx) : (sx > {1'b0, LIM_X});
                py_d    = dy_q ? ((ey >= sty) ? dfy[Y_W-1:0] : '0) : ((sy <= {1'b0, LIM_Y}) ? sy[Y_W-1:0] : LIM_Y);
                dy_d    = dy_q ? (ey >= sty) : (sy > {1'b0, LIM_Y});
                state_d = DRAW;
                col_d   = iColour;
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        frame_d = (state_d == MOVE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            px_q    <= '0;
            py_q    <= '0;
            dx_q    <= 1'b0;
            dy_q    <= 1'b0;
            col_q   <= '0;
            tick_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            oc_q    <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            col_q   <= col_d;
            tick_q  <= tick_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oc_q    <= oc_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
        end
    end

    assign oX      = ox_q;
    assign oY      = oy_q;
    assign oColour = oc_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oFrame  = frame_q;
endmodule

// File: tb/tb_box_animator.sv
// tb_box_animator: directed checks of scan order, handshake stalls, timing, bounce, clamp and reset.
module tb_box_animator;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       iLoad, iEnable, iReady;
    logic [7:0] iX;
    logic [6:0] iY;
    logic [2:0] iColour;
    logic [1:0] iStep;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oBusy, oFrame;
    logic [20:0] outs;
    int checks = 0;
    int failures = 0;
    int x, y, n, p;

    box_animator #(.FRAME_TICKS(8)) dut (
        .clock(clock), .resetn(resetn), .iLoad(iLoad), .iX(iX), .iY(iY),
        .iColour(iColour), .iStep(iStep), .iEnable(iEnable), .iReady(iReady),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oFrame(oFrame)
    );

    assign outs = {oX, oY, oColour, oPlot, oBusy, oFrame};

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scans one 4x4 pass; iColour is rewritten at the first plot to prove mid-scan changes are ignored.
    task automatic scan(input int x0, input int y0, input int col, input int mid, input bit thr, input int lead_exp);
        int k = 0;
        int m = 0;
        int lead = 0;
        bit seen = 1'b0;
        while (k < 16 && m < 300) begin
            @(negedge clock);
            m++;
            iLoad = 1'b0;
            iReady = thr ? (m % 3 == 0) : 1'b1;
            if (!oPlot && !seen) lead++;
            if (oPlot) begin
                if (!seen) iColour = 3'(mid);
                seen = 1'b1;
                check("pix", int'({oX, oY, oColour}), ((x0 + k % 4) << 10) | ((y0 + k / 4) << 3) | col);
                if (iReady) k++;
            end
        end
        check("lead", lead, lead_exp);
        check("count", k, 16);
        @(negedge clock);
        iReady = 1'b1;
        check("plot_end", int'(oPlot), 0);
    endtask

    task automatic wait_idle(output int cyc, output int plots);
        cyc = 0;
        plots = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (oPlot) plots++;
            if (cyc == 2) iLoad = 1'b0;
        end while (oBusy && cyc < 200);
        check("idle", int'(oBusy), 0);
    endtask

    task automatic frame_pos(output int fx, output int fy);
        int m = 0;
        while (!oFrame && m < 100) begin
            @(negedge clock);
            m++;
        end
        check("frame_seen", int'(oFrame), 1);
        m = 0;
        while (!oPlot && m < 10) begin
            @(negedge clock);
            m++;
        end
        check("frame_plot", int'(oPlot), 1);
        fx = oX;
        fy = oY;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "watchdog");
    end

    initial begin
        iLoad = 0; iX = 0; iY = 0; iColour = 0; iStep = 0; iEnable = 0; iReady = 0;
        repeat (3) @(negedge clock);
        check("rst_hold", int'(outs), 0);
        resetn = 1'b1;
        @(negedge clock);
        check("rst_out", int'(outs), 0);

        iLoad = 1; iX = 10; iY = 20; iColour = 5; iStep = 1; iEnable = 1; iReady = 1;
        scan(10, 20, 5, 3, 1'b0, 1);
        scan(10, 20, 0, 3, 1'b0, 8);
        check("frame", int'(oFrame), 1);
        check("busy", int'(oBusy), 1);
        scan(11, 21, 3, 3, 1'b1, 1);

        iEnable = 0; iLoad = 1; iX = 50; iY = 50;
        wait_idle(n, p);
        check("idle_lat", n, 8);
        check("no_erase", p, 0);
        iColour = 6; iEnable = 1;
        scan(11, 21, 6, 6, 1'b0, 1);
        iEnable = 0;
        wait_idle(n, p);
        check("idle_lat2", n, 8);

        iLoad = 1; iX = 155; iY = 115; iStep = 3; iColour = 2; iEnable = 1;
        scan(155, 115, 2, 2, 1'b0, 1);
        scan(155, 115, 0, 2, 1'b0, 8);
        check("frame_b1", int'(oFrame), 1);
        scan(156, 116, 2, 2, 1'b0, 1);
        scan(156, 116, 0, 2, 1'b0, 8);
        check("frame_b2", int'(oFrame), 1);
        scan(153, 113, 2, 2, 1'b0, 1);
        for (int k = 3; k <= 55; k++) begin
            frame_pos(x, y);
            case (k)
                39: check("pos39", (x << 8) | y, (42 << 8) | 2);
                40: check("pos40", (x << 8) | y, (39 << 8) | 0);
                41: check("pos41", (x << 8) | y, (36 << 8) | 3);
                53: check("pos53", (x << 8) | y, (0 << 8) | 39);
                54: check("pos54", (x << 8) | y, (0 << 8) | 42);
                55: check("pos55", (x << 8) | y, (3 << 8) | 45);
                default: ;
            endcase
        end
        iEnable = 0;
        wait_idle(n, p);

        iLoad = 1; iX = 200; iY = 127; iColour = 4; iEnable = 1;
        scan(156, 116, 4, 4, 1'b0, 1);
        iEnable = 0;
        wait_idle(n, p);

        iLoad = 1; iX = 30; iY = 40; iColour = 7; iEnable = 1;
        begin
            int k = 0;
            int m = 0;
            while (m < 100) begin
                @(negedge clock);
                m++;
                iLoad = 0;
                iEnable = 0;
                if (oPlot) begin
                    if (k == 6) break;
                    k++;
                end
            end
        end
        check("rst_pix", int'({oX, oY, oColour}), (32 << 10) | (41 << 3) | 7);
        resetn = 1'b0;
        #1;
        check("rst_async", int'({oPlot, oBusy}), 0);
        repeat (2) @(negedge clock);
        check("rst_mid", int'(outs), 0);
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("rst_rel", int'(outs), 0);
        end
        iColour = 1; iEnable = 1;
        scan(0, 0, 1, 1, 1'b0, 1);
        iEnable = 0;
        wait_idle(n, p);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
